fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clk  in  1  single rising-edge clock for the stage.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 stall  in  1  hazard hold from decode; freezes PC and the IF/ID register.
REQ-004 branch_taken  in  1  redirect request resolved in decode.
REQ-005 branch_target  in  16  redirect byte address.
REQ-006 imem_data  in  16  instruction word at imem_addr; combinational read, same cycle.
REQ-007 imem_addr  out  16  fetch address; always equals pc.
REQ-008 pc  out  16  current PC register.
REQ-009 F_instruction  out  16  instruction fetched this cycle.
REQ-010 F_hlt  out  1  the fetched instruction is HLT and is not being squashed.
REQ-011 FD_instruction  out  16  IF/ID instruction register.
REQ-012 FD_pc_plus2  out  16  IF/ID copy of the fetch PC + 2.
REQ-013 FD_valid  out  1  the IF/ID register holds a real instruction, not a bubble.
REQ-014 fetch_count  out  16  count of instructions accepted into IF/ID; saturates.

Function
REQ-015 pc_plus2 SHALL be pc + 2, modulo 2^16: 0xFFFE wraps to 0x0000 with no flag.
REQ-016 F_instruction SHALL equal imem_data in RUN and NOP (0x0000) in HALTED.
REQ-017 F_hlt SHALL be 1 iff state is RUN, imem_data[15:12] == OPC_HLT, and branch_taken == 0.
REQ-018 States: RUN and HALTED.
  - RUN to HALTED when F_hlt == 1 and stall == 0.
  - HALTED to RUN only on branch_taken == 1.
REQ-019 Next-PC priority, highest first:
  1. branch_taken: pc <= branch_target.
  2. stall: pc holds.
  3. HALTED, or F_hlt: pc holds.
  4. Otherwise: pc <= pc_plus2.
REQ-020 IF/ID update priority, highest first:
  1. branch_taken: FD_valid <= 0, FD_instruction <= 0x0000.
  2. stall: all FD_* hold.
  3. Otherwise: FD_instruction <= F_instruction, FD_pc_plus2 <= pc_plus2, FD_valid <= (state == RUN).
REQ-021 The HLT word itself SHALL be loaded into IF/ID with FD_valid = 1 so it travels down the pipe; all later fetches while HALTED load bubbles.
REQ-022 fetch_count SHALL increment by 1 on each cycle in which IF/ID loads with FD_valid <= 1; it saturates at 0xFFFF.
REQ-023 branch_taken and stall asserted together: branch wins; the IF/ID register is squashed, not held.
REQ-024 Latency: the instruction at address A SHALL appear on FD_instruction one cycle after pc == A, provided stall == 0 and branch_taken == 0.

Reset
REQ-025 rst SHALL act asynchronously and force:
  - pc = RESET_PC (0x0000), state = RUN;
  - FD_instruction = 0x0000, FD_pc_plus2 = 0x0000, FD_valid = 0;
  - fetch_count = 0.
REQ-026 rst asserted mid-stall or mid-halt SHALL discard all pending state; the first fetch after deassertion is at 0x0000.

Structure
REQ-027 Package wisc_pkg SHALL hold OPC_HLT (4'hF), NOP_INSTR (16'h0000), RESET_PC (16'h0000), the 16-bit data width, and the RUN/HALTED state enum.
REQ-028 The IF/ID register SHALL be a sub-module if_id_reg: 16+16+1 bits, with inputs load, squash, data, and the async reset.
REQ-029 The PC register and halt FSM SHALL live in fetch_stage.

Verification
REQ-030 Straight-line code: imem holds 0x1123 at 0x0000 and 0x2234 at 0x0002, no stall or branch -> pc goes 0,2,4; FD_instruction = 0x1123 then 0x2234; fetch_count = 2 after two cycles.
REQ-031 stall high for 3 cycles with pc = 0x0004 -> pc stays 0x0004 and all FD_* hold; fetch_count is unchanged.
REQ-032 branch_taken with target 0x0040 while stall = 1 -> next pc = 0x0040; FD_valid = 0 and FD_instruction = 0x0000 the following cycle.
REQ-033 HLT (0xF000) at 0x0006 -> F_hlt = 1 for one cycle; the HLT enters IF/ID with FD_valid = 1; pc then stays 0x0006, later FD_valid = 0, and fetch_count stops.
REQ-034 While HALTED, branch_taken with target 0x0010 -> state returns to RUN, pc = 0x0010, and fetch resumes.
REQ-035 pc = 0xFFFE with no stall -> next pc = 0x0000; FD_pc_plus2 = 0x0000. Separately, rst pulsed mid-cycle during a stall -> every output is at its reset value immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wisc_pkg.sv
// ---------------------------------------------------------------------------
// wisc_pkg
// Shared definitions for the fetch stage: the data width, the HLT opcode, the
// NOP word, the reset PC, the fetch state enum and the IF/ID payload struct.
// This package has no ports.
// ---------------------------------------------------------------------------
package wisc_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] word_t;

    localparam logic [3:0] OPC_HLT   = 4'hF;
    localparam word_t      NOP_INSTR = 16'h0000;
    localparam word_t      RESET_PC  = 16'h0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetchState_t;

    // Payload of the IF/ID pipeline register: 16 + 16 + 1 bits.
    typedef struct packed {
        word_t instr;
        word_t pcPlus2;
        logic  valid;
    } ifId_t;

    function automatic logic isHlt(input word_t instr);
        return instr[15:12] == OPC_HLT;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Bundles the fetch stage's control inputs, instruction-memory port and
// IF/ID outputs.
//   master : the fetch stage (drives imem_addr, pc, F_*, FD_*, fetch_count)
//   slave  : the surroundings (decode control, instruction memory)
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    import wisc_pkg::*;

    logic  stall;
    logic  branch_taken;
    word_t branch_target;
    word_t imem_data;
    word_t imem_addr;
    word_t pc;
    word_t F_instruction;
    logic  F_hlt;
    word_t FD_instruction;
    word_t FD_pc_plus2;
    logic  FD_valid;
    word_t fetch_count;

    modport master (
        input  stall, branch_taken, branch_target, imem_data,
        output imem_addr, pc, F_instruction, F_hlt,
               FD_instruction, FD_pc_plus2, FD_valid, fetch_count
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_data,
        input  imem_addr, pc, F_instruction, F_hlt,
               FD_instruction, FD_pc_plus2, FD_valid, fetch_count
    );

endinterface

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset, clears everything
//   load   : capture data this cycle
//   squash : turn the entry into a bubble (wins over load)
//   data   : next instruction / pc+2 / valid
//   q      : registered contents
// A squash clears instr and valid only; pcPlus2 is meaningless in a bubble
// and simply holds.
// ---------------------------------------------------------------------------
module if_id_reg
    import wisc_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  squash,
    input  ifId_t data,
    output ifId_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (squash) begin
            q.instr <= NOP_INSTR;
            q.valid <= 1'b0;
        end else if (load) begin
            q <= data;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: PC register, RUN/HALTED FSM, saturating fetch counter
// and the IF/ID register.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : fetch_stage_if.master
//         in  : stall, branch_taken, branch_target, imem_data
//         out : imem_addr (= pc), pc, F_instruction, F_hlt,
//               FD_instruction, FD_pc_plus2, FD_valid, fetch_count
// Memory is read combinationally: imem_data is the word at the current pc.
// An HLT word is passed down the pipe once with FD_valid set; afterwards the
// PC parks on it and bubbles are issued until a branch redirects fetch.
// ---------------------------------------------------------------------------
module fetch_stage
    import wisc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    fetchState_t state;
    word_t       pc;
    word_t       pcPlus2;
    word_t       fInstr;
    logic        fHlt;
    logic        acceptValid;
    logic        fdLoad;
    word_t       fetchCount;
    ifId_t       fdNext;
    ifId_t       fdQ;

    // Natural 16-bit wrap: 0xFFFE + 2 = 0x0000.
    assign pcPlus2 = pc + 16'd2;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        fInstr = NOP_INSTR;
        fHlt   = 1'b0;
        if (state == RUN) begin
            fInstr = bus.imem_data;
            fHlt   = isHlt(bus.imem_data) && !bus.branch_taken;
        end
    end

    // IF/ID takes a real instruction only when running, not stalled and not
    // being squashed; that is exactly when the fetch counter advances.
    assign acceptValid = (state == RUN) && !bus.stall && !bus.branch_taken;
    assign fdLoad      = !bus.stall;
    assign fdNext      = '{instr: fInstr, pcPlus2: pcPlus2, valid: (state == RUN)};

    // PC register and halt FSM. A branch overrides both stall and halt.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else if (bus.branch_taken) begin
            state <= RUN;
            pc    <= bus.branch_target;
        end else if (!bus.stall && state == RUN) begin
            if (fHlt) begin
                state <= HALTED;   // pc parks on the HLT word
            end else begin
                pc    <= pcPlus2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchCount <= '0;
        end else if (acceptValid && fetchCount != '1) begin
            fetchCount <= fetchCount + 16'd1;
        end
    end

    if_id_reg u_ifId (
        .clk    (clk),
        .rst    (rst),
        .load   (fdLoad),
        .squash (bus.branch_taken),
        .data   (fdNext),
        .q      (fdQ)
    );

    assign bus.imem_addr      = pc;
    assign bus.pc             = pc;
    assign bus.F_instruction  = fInstr;
    assign bus.F_hlt          = fHlt;
    assign bus.FD_instruction = fdQ.instr;
    assign bus.FD_pc_plus2    = fdQ.pcPlus2;
    assign bus.FD_valid       = fdQ.valid;
    assign bus.fetch_count    = fetchCount;

endmodule
